// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding select encodings, stall FSM states
// and the default register address width.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_t;

endpackage

// File: rtl/fwd_select.sv
// Single-source forwarding priority comparator.
// Ports: exmem_regwrite/exmem_rd and memwb_regwrite/memwb_rd describe the two
// in-flight producers; rs is the consumer source register; sel is the operand
// mux select (EX/MEM beats MEM/WB, register 0 optionally excluded).
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [REG_ADDR_W-1:0] rs,
  output logic [1:0]            sel
);

  logic excluded;
  logic ex_hit;
  logic mem_hit;

  assign excluded = (ZERO_REG_EN != 0) && (rs == '0);
  assign ex_hit   = exmem_regwrite && (exmem_rd == rs) && !excluded;
  assign mem_hit  = memwb_regwrite && (memwb_rd == rs) && !excluded;

  // Younger producer (EX/MEM) holds the most recent value, so it wins.
  always_comb begin
    sel = FWD_REGFILE;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard unit beside the ID/EX stage.
// Ports: clk/reset (sync, active-high); EX/MEM and MEM/WB write-back info;
// ID/EX sources, load flag and destination; IF/ID sources and used mask;
// flush from branch/exception. Outputs: fwd_sel (2 bits per source, zero
// latency), stall (hold PC and IF/ID), idex_bubble (NOP into ID/EX) and a
// saturating stall_count.
module hazard_forward_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned ZERO_REG_EN = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          exmem_regwrite,
  input  logic [REG_ADDR_W-1:0]         exmem_rd,
  input  logic                          memwb_regwrite,
  input  logic [REG_ADDR_W-1:0]         memwb_rd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] idex_rs,
  input  logic                          idex_memread,
  input  logic [REG_ADDR_W-1:0]         idex_rd,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ifid_rs,
  input  logic [NUM_SRC-1:0]            ifid_src_used,
  input  logic                          flush,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall,
  output logic                          idex_bubble,
  output logic [CNT_W-1:0]              stall_count
);

  // Remaining STALL-state cycles; only ever holds up to LOAD_LAT-1.
  localparam int unsigned REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  stall_state_t       state;
  stall_state_t       state_next;
  logic [REM_W-1:0]   rem;
  logic [REM_W-1:0]   rem_next;
  logic [2*NUM_SRC-1:0] fwd_raw;
  logic               hz;
  logic               src_match;
  logic               stall_int;
  logic               bubble_int;

  // One priority comparator per source operand.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_select #(
      .REG_ADDR_W (REG_ADDR_W),
      .ZERO_REG_EN(ZERO_REG_EN)
    ) u_fwd_select (
      .exmem_regwrite(exmem_regwrite),
      .exmem_rd      (exmem_rd),
      .memwb_regwrite(memwb_regwrite),
      .memwb_rd      (memwb_rd),
      .rs            (idex_rs[g*REG_ADDR_W +: REG_ADDR_W]),
      .sel           (fwd_raw[2*g +: 2])
    );
  end

  // Load-use detection: a used IF/ID source reads the load's destination.
  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (ifid_src_used[i] && (ifid_rs[i*REG_ADDR_W +: REG_ADDR_W] == idex_rd)) begin
        src_match = 1'b1;
      end
    end
    hz = idex_memread && src_match && !((ZERO_REG_EN != 0) && (idex_rd == '0));
  end

  // Next-state and stall/bubble decode; flush overrides everything.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    stall_int  = 1'b0;
    bubble_int = 1'b0;
    if (flush) begin
      bubble_int = 1'b1;
      state_next = IDLE;
      rem_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          stall_int  = hz;
          bubble_int = hz;
          if (hz && (LOAD_LAT > 1)) begin
            state_next = STALL;
            rem_next   = REM_W'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          // hz ignored here: ID/EX already carries a bubble.
          stall_int  = 1'b1;
          bubble_int = 1'b1;
          rem_next   = rem - REM_W'(1);
          if (rem == REM_W'(1)) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          rem_next   = '0;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, including mid-stall.
  assign stall       = !reset && stall_int;
  assign idex_bubble = !reset && bubble_int;
  assign fwd_sel     = reset ? '0 : fwd_raw;

  // State, remaining-cycle counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_LAT=1/zero-reg excluded/
// 16-bit counter, and LOAD_LAT=3/zero-reg forwarded/4-bit counter) share one
// stimulus stream and are checked against a behavioural reference model.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       exw;
  logic [4:0] exrd;
  logic       mww;
  logic [4:0] mwrd;
  logic [9:0] idrs;
  logic       idmr;
  logic [4:0] idrd;
  logic [9:0] ifrs;
  logic [1:0] used;
  logic       flush;

  logic [3:0]  fa, fb;
  logic        sa, ba, sb, bb;
  logic [15:0] ca;
  logic [3:0]  cb;

  int n_checks = 0;
  int n_fail   = 0;
  int rem_a, rem_b, cnt_a, cnt_b;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_EN(1), .CNT_W(16)
  ) u_a (
    .clk(clk), .reset(reset),
    .exmem_regwrite(exw), .exmem_rd(exrd),
    .memwb_regwrite(mww), .memwb_rd(mwrd),
    .idex_rs(idrs), .idex_memread(idmr), .idex_rd(idrd),
    .ifid_rs(ifrs), .ifid_src_used(used), .flush(flush),
    .fwd_sel(fa), .stall(sa), .idex_bubble(ba), .stall_count(ca)
  );

  hazard_forward_unit #(
    .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_EN(0), .CNT_W(4)
  ) u_b (
    .clk(clk), .reset(reset),
    .exmem_regwrite(exw), .exmem_rd(exrd),
    .memwb_regwrite(mww), .memwb_rd(mwrd),
    .idex_rs(idrs), .idex_memread(idmr), .idex_rd(idrd),
    .ifid_rs(ifrs), .ifid_src_used(used), .flush(flush),
    .fwd_sel(fb), .stall(sb), .idex_bubble(bb), .stall_count(cb)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected operand selects from the forwarding rules.
  function automatic logic [3:0] ref_fwd(input bit zen);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] s = idrs[i*5 +: 5];
      bit excl = zen && (s == 5'd0);
      if (!excl && exw && exrd == s) r[i*2 +: 2] = 2'b01;
      else if (!excl && mww && mwrd == s) r[i*2 +: 2] = 2'b10;
    end
    return r;
  endfunction

  function automatic bit ref_hz(input bit zen);
    if (!idmr) return 1'b0;
    if (zen && idrd == 5'd0) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (used[i] && ifrs[i*5 +: 5] == idrd) return 1'b1;
    return 1'b0;
  endfunction

  // rem = stall cycles still owed after the current one for an earlier hazard.
  task automatic model_out(input int lat, input bit zen, input int rem,
                           output bit st, output bit bub, output int nrem);
    st = 1'b0; bub = 1'b0; nrem = 0;
    if (reset) begin
      nrem = 0;
    end else if (flush) begin
      bub = 1'b1;
    end else if (rem > 0) begin
      st = 1'b1; bub = 1'b1; nrem = rem - 1;
    end else if (ref_hz(zen)) begin
      st = 1'b1; bub = 1'b1; nrem = lat - 1;
    end
  endtask

  // Inputs are already set (at negedge); check both instances, then advance.
  task automatic step();
    bit sta, bua, stb, bub;
    int nra, nrb;
    #1;
    model_out(1, 1'b1, rem_a, sta, bua, nra);
    model_out(3, 1'b0, rem_b, stb, bub, nrb);
    check_val("fwd_a", 32'(fa), reset ? 32'd0 : 32'(ref_fwd(1'b1)));
    check_val("fwd_b", 32'(fb), reset ? 32'd0 : 32'(ref_fwd(1'b0)));
    check_val("stall_a", 32'(sa), 32'(sta));
    check_val("bubble_a", 32'(ba), 32'(bua));
    check_val("stall_b", 32'(sb), 32'(stb));
    check_val("bubble_b", 32'(bb), 32'(bub));
    check_val("count_a", 32'(ca), 32'(cnt_a));
    check_val("count_b", 32'(cb), 32'(cnt_b));
    @(posedge clk);
    if (reset) begin
      cnt_a = 0; cnt_b = 0;
    end else begin
      if (sta && cnt_a < 65535) cnt_a++;
      if (stb && cnt_b < 15) cnt_b++;
    end
    rem_a = nra;
    rem_b = nrb;
    @(negedge clk);
  endtask

  task automatic quiet();
    exw = 0; exrd = 0; mww = 0; mwrd = 0; idrs = 0;
    idmr = 0; idrd = 0; ifrs = 0; used = 0; flush = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset state: all outputs quiet even with forwarding hits present.
    exw = 1; exrd = 5; idrs = {5'd5, 5'd5};
    #1 check_val("rst_fwd", 32'(fa), 32'd0);
    check_val("rst_count", 32'(ca), 32'd0);
    step();
    quiet();
    reset = 1'b0;

    // Forwarding priority, then MEM/WB alone.
    exw = 1; exrd = 5; mww = 1; mwrd = 5; idrs = {5'd5, 5'd5};
    #1 check_val("prio_ex", 32'(fa), 32'h5);
    step();
    exw = 0;
    #1 check_val("prio_mem", 32'(fa), 32'hA);
    step();

    // Zero register: excluded on A, forwarded on B.
    quiet();
    exw = 1; exrd = 0; idrs = 10'd0;
    #1 check_val("zero_excl", 32'(fa), 32'h0);
    check_val("zero_fwd", 32'(fb), 32'h5);
    step();
    quiet();

    // Load-use: A stalls 1 cycle, B stalls 3.
    do_reset();
    idmr = 1; idrd = 7; ifrs = {5'd0, 5'd7}; used = 2'b01;
    #1 check_val("lu_stall_a", 32'(sa), 32'd1);
    step();
    quiet();
    #1 check_val("lu_a_release", 32'(sa), 32'd0);
    check_val("lu_b_hold1", 32'(sb), 32'd1);
    step();
    #1 check_val("lu_b_hold2", 32'(sb), 32'd1);
    step();
    #1 check_val("lu_b_release", 32'(sb), 32'd0);
    check_val("lu_count_a", 32'(ca), 32'd1);
    check_val("lu_count_b", 32'(cb), 32'd3);
    step();

    // Source not used: no hazard.
    idmr = 1; idrd = 7; ifrs = {5'd7, 5'd7}; used = 2'b00;
    #1 check_val("unused_a", 32'(sa), 32'd0);
    check_val("unused_b", 32'(sb), 32'd0);
    step();
    quiet();

    // Flush in the second stall cycle of B.
    do_reset();
    idmr = 1; idrd = 9; ifrs = {5'd9, 5'd0}; used = 2'b10;
    step();
    quiet();
    flush = 1;
    #1 check_val("flush_stall_b", 32'(sb), 32'd0);
    check_val("flush_bubble_b", 32'(bb), 32'd1);
    step();
    flush = 0;
    #1 check_val("flush_idle_b", 32'(sb), 32'd0);
    check_val("flush_count_b", 32'(cb), 32'd1);
    step();

    // Saturation of B's 4-bit counter, then reset mid-stall.
    do_reset();
    idmr = 1; idrd = 3; ifrs = {5'd3, 5'd3}; used = 2'b11;
    for (int i = 0; i < 20; i++) step();
    #1 check_val("sat_count_b", 32'(cb), 32'd15);
    check_val("sat_count_a", 32'(ca), 32'd20);
    reset = 1'b1;
    #1 check_val("rst_mid_stall_b", 32'(sb), 32'd0);
    step();
    reset = 1'b0;
    quiet();
    #1 check_val("rst_mid_count_b", 32'(cb), 32'd0);
    step();

    // Randomized traffic over a small register range to provoke hits.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      exw   = 1'($urandom_range(0, 1));
      mww   = 1'($urandom_range(0, 1));
      exrd  = 5'($urandom_range(0, 3));
      mwrd  = 5'($urandom_range(0, 3));
      idrs  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      idmr  = ($urandom_range(0, 2) == 0);
      idrd  = 5'($urandom_range(0, 3));
      ifrs  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      used  = 2'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised forwarding and hazard unit for the pipelined core. It generates per-source-operand forwarding selects with EX/MEM-over-MEM/WB priority and zero-register exclusion. It detects load-use hazards and runs a stall FSM that holds PC and IF/ID and injects ID/EX bubbles for a configurable load latency. It sits beside the ID/EX stage, drives the EX operand muxes and the front-end hold/bubble controls, and keeps a saturating stall-cycle counter for performance tracking.

Parameters:
REG_ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction (minimum 1)
LOAD_LAT, 1, load-use stall cycles (minimum 1)
ZERO_REG_EN, 1, 1 means register 0 is never forwarded or hazard-checked
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
exmem_regwrite  in  1  EX/MEM instruction writes a register
exmem_rd  in  REG_ADDR_W  EX/MEM destination register
memwb_regwrite  in  1  MEM/WB instruction writes a register
memwb_rd  in  REG_ADDR_W  MEM/WB destination register
idex_rs  in  NUM_SRC*REG_ADDR_W  ID/EX source registers; source i is at bits [i*W +: W]
idex_memread  in  1  ID/EX instruction is a load
idex_rd  in  REG_ADDR_W  ID/EX destination register
ifid_rs  in  NUM_SRC*REG_ADDR_W  IF/ID source registers
ifid_src_used  in  NUM_SRC  IF/ID source i is actually read
flush  in  1  branch/exception squash of the front end
fwd_sel  out  2*NUM_SRC  per-source select: 00 regfile, 01 EX/MEM, 10 MEM/WB (11 is never driven)
stall  out  1  hold PC and IF/ID
idex_bubble  out  1  load a NOP into ID/EX
stall_count  out  CNT_W  total stall cycles

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on reset.
- Reset: state IDLE, remaining-cycle counter 0, stall_count 0. While reset is high, stall, idex_bubble and fwd_sel are all 0.
- Forwarding is combinational, zero latency, per source i:
  - ex_hit = exmem_regwrite & (exmem_rd == rs_i) & ~(ZERO_REG_EN & rs_i == 0)
  - mem_hit is the same test using memwb_regwrite and memwb_rd
  - ex_hit gives 01; else mem_hit gives 10; else 00. EX/MEM wins when both hit.
- Load-use hazard: hz = idex_memread & ~(ZERO_REG_EN & idex_rd == 0) & OR over i of (ifid_src_used[i] & ifid_rs_i == idex_rd).
- FSM state IDLE:
  - stall = hz & ~flush
  - idex_bubble = (hz | flush)
  - If hz & ~flush & LOAD_LAT > 1: go to STALL and load the counter with LOAD_LAT-1.
- FSM state STALL:
  - stall = 1 and idex_bubble = 1.
  - Counter decrements each cycle. When the counter is 1, return to IDLE on the next edge.
  - hz is ignored in STALL because ID/EX already holds a bubble.
- Flush has priority in any state: stall = 0, idex_bubble = 1, next state IDLE, counter cleared.
- Reset mid-stall returns to IDLE on the next edge; stall deasserts in that same cycle.
- stall_count increments on each edge where stall = 1. It saturates at 2^CNT_W - 1 and does not wrap. It is cleared only by reset.
- Total stall cycles per load-use hazard equal exactly LOAD_LAT when no flush occurs.

Decomposition:
- Shared pkg pipeline_pkg holds:
  - fwd_sel encodings FWD_REGFILE = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10
  - FSM state typedef (IDLE, STALL)
  - default REG_ADDR_W
- One sub-module, fwd_select: a single-source priority comparator instantiated NUM_SRC times via generate. The FSM and counter stay in the top module.

Test Plan:
1. Forwarding priority (NUM_SRC=2): exmem_regwrite=1, exmem_rd=5; memwb_regwrite=1, memwb_rd=5; idex_rs={5,5} -> fwd_sel=4'b0101. Drop exmem_regwrite -> fwd_sel=4'b1010.
2. Zero register: exmem_rd=0, idex_rs={0,0}, exmem_regwrite=1 -> fwd_sel=0. Repeat with ZERO_REG_EN=0 -> fwd_sel=4'b0101.
3. Load-use, LOAD_LAT=1: idex_memread=1, idex_rd=7, ifid_rs[0]=7, src_used=2'b01 -> stall=1 and idex_bubble=1 for exactly 1 cycle; stall_count=1. Same with src_used=2'b00 -> no stall.
4. LOAD_LAT=3: hazard on cycle N -> stall high on cycles N, N+1, N+2 and low on N+3; stall_count=3.
5. Flush mid-stall (LOAD_LAT=3): flush on cycle N+1 -> stall=0 and bubble=1 on N+1; state IDLE on N+2; stall_count=1.
6. Saturation (CNT_W=4): force 20 stall cycles -> stall_count holds at 15. Reset asserted mid-STALL -> next cycle stall=0 and stall_count=0.
